// File: rtl/fifo_frame_sequencer_pkg.sv
// Shared types and widths for the FIFO read-side frame sequencer.
package fifo_frame_sequencer_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned SEQ_W  = 8;
   localparam int unsigned SYNC_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_PAD     = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/fifo_frame_sequencer_if.sv
// FIFO read port plus outgoing valid/ready stream of the frame sequencer.
interface fifo_frame_sequencer_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      input  fifo_empty, fifo_rdata, m_ready,
      output fifo_rd_en, m_data, m_valid, m_last
   );

   modport slave (
      output fifo_empty, fifo_rdata, m_ready,
      input  fifo_rd_en, m_data, m_valid, m_last
   );
endinterface

// File: rtl/fifo_frame_sequencer_skid.sv
// Two-entry register buffer between FIFO read data and the output stream.
module seq_skid_buffer #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            count
);
   logic [DATA_WIDTH-1:0] mem0, mem1;

   assign head = mem0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0  <= '0;
         mem1  <= '0;
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) mem0 <= push_data;
               else               mem1 <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               mem0  <= mem1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  mem0 <= push_data;
               end else begin
                  mem0 <= mem1;
                  mem1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/fifo_frame_sequencer.sv
// Frames FIFO samples as header + FRAME_LEN payload words, padding on producer timeout.
module fifo_frame_sequencer
   import fifo_frame_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAME_LEN  = 64,
   parameter int unsigned TIMEOUT    = 256,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   fifo_frame_sequencer_if.master bus,
   output logic                  underrun,
   output logic                  busy,
   output logic [SEQ_W-1:0]      seq_num
);
   localparam int unsigned       IDLE_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  LEN      = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

   state_t                state;
   logic [CNT_W-1:0]      issued, sent;
   logic [IDLE_W-1:0]     idle_cnt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] head, hdr, data;
   logic [1:0]            count, occ;
   logic                  buf_valid, pad_word, valid, last;
   logic                  in_frame, xfer, pop, frame_end, rd_en, rd_accept;

   seq_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (bus.fifo_rdata),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   always_comb begin
      hdr = '0;
      hdr[DATA_WIDTH-1 -: SYNC_W] = SYNC_BYTE;
      hdr[SEQ_W-1:0] = seq_num;
   end

   assign buf_valid = (count != 2'd0);
   assign pad_word  = (state == ST_PAD) && !buf_valid && !inflight;
   assign in_frame  = (state == ST_PAYLOAD) || (state == ST_PAD);

   always_comb begin
      valid = 1'b0;
      data  = '0;
      last  = 1'b0;
      case (state)
         ST_HEADER: begin
            valid = 1'b1;
            data  = hdr;
         end
         ST_PAYLOAD: begin
            valid = buf_valid;
            data  = head;
            last  = buf_valid && (sent == LAST_IDX);
         end
         ST_PAD: begin
            valid = buf_valid || pad_word;
            data  = buf_valid ? head : '0;
            last  = valid && (sent == LAST_IDX);
         end
         default: ;
      endcase
   end

   assign xfer      = valid && bus.m_ready;
   assign pop       = xfer && buf_valid && in_frame;
   assign frame_end = xfer && in_frame && (sent == LAST_IDX);
   // Occupancy excludes the word leaving this cycle so reads sustain one word per clock.
   assign occ       = count - {1'b0, pop} + {1'b0, inflight};
   assign rd_en     = (state == ST_PAYLOAD) && !bus.fifo_empty && (occ < 2'd2) && (issued < LEN);
   assign rd_accept = rd_en && !bus.fifo_empty;
   assign busy      = (state != ST_IDLE);

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = valid;
   assign bus.m_data     = data;
   assign bus.m_last     = last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         issued   <= '0;
         sent     <= '0;
         idle_cnt <= '0;
         inflight <= 1'b0;
         underrun <= 1'b0;
         seq_num  <= '0;
      end else begin
         underrun <= 1'b0;
         inflight <= rd_accept;
         if (rd_accept) issued <= issued + CNT_W'(1);
         if (xfer && in_frame) sent <= sent + CNT_W'(1);
         case (state)
            ST_IDLE: begin
               if (enable && !bus.fifo_empty) state <= ST_HEADER;
            end
            ST_HEADER: begin
               if (xfer) begin
                  state    <= ST_PAYLOAD;
                  issued   <= '0;
                  sent     <= '0;
                  idle_cnt <= '0;
               end
            end
            ST_PAYLOAD: begin
               if (rd_accept) begin
                  idle_cnt <= '0;
               end else if (bus.fifo_empty && (issued < LEN)) begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
                  if (idle_cnt == IDLE_MAX) begin
                     state    <= ST_PAD;
                     underrun <= 1'b1;
                  end
               end
               if (frame_end) state <= ST_DONE;
            end
            ST_PAD: begin
               if (frame_end) state <= ST_DONE;
            end
            ST_DONE: begin
               seq_num <= seq_num + SEQ_W'(1);
               state   <= (enable && !bus.fifo_empty) ? ST_HEADER : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_frame_sequencer.sv
// Directed bench: FIFO model feeding the sequencer, stream monitor, per-scenario checks.
module tb_fifo_frame_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable = 1'b0;
   logic       underrun, busy;
   logic [7:0] seq_num;

   fifo_frame_sequencer_if #(.DATA_WIDTH(16)) bus ();

   fifo_frame_sequencer #(
      .DATA_WIDTH (16),
      .FRAME_LEN  (4),
      .TIMEOUT    (8),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .bus      (bus.master),
      .underrun (underrun),
      .busy     (busy),
      .seq_num  (seq_num)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int reads = 0;
   int ur_count = 0;
   int ur_cyc = 0;
   int last_rd_edge = 0;
   int stall_err = 0;
   int last_count = 0;
   logic        do_rd = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_d = '0;
   logic        prev_l = 1'b0;
   logic [15:0] fq[$];
   logic [15:0] cap_d[$];
   logic        cap_l[$];
   int          cap_c[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor and FIFO read sampling, away from the active edge.
   always @(negedge clk) begin
      do_rd = bus.fifo_rd_en && !bus.fifo_empty;
      if (do_rd) last_rd_edge = cyc + 1;
      if (rst_n && prev_stall &&
          (!bus.m_valid || bus.m_data !== prev_d || bus.m_last !== prev_l))
         stall_err++;
      prev_stall = rst_n && bus.m_valid && !bus.m_ready;
      prev_d = bus.m_data;
      prev_l = bus.m_last;
      if (rst_n && bus.m_valid && bus.m_ready) begin
         cap_d.push_back(bus.m_data);
         cap_l.push_back(bus.m_last);
         cap_c.push_back(cyc);
         if (bus.m_last) last_count++;
      end
      if (rst_n && underrun) begin
         ur_count++;
         ur_cyc = cyc;
      end
   end

   // FIFO model: data appears the cycle after an accepted read.
   always @(posedge clk) begin
      #1;
      if (do_rd && fq.size() != 0) begin
         bus.fifo_rdata = fq.pop_front();
         reads++;
      end
      bus.fifo_empty = (fq.size() == 0);
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      enable = 1'b0;
      bus.m_ready = 1'b0;
      fq.delete();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      cap_d.delete();
      cap_l.delete();
      cap_c.delete();
      last_count = 0;
      ur_count = 0;
      reads = 0;
      stall_err = 0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.m_valid); end
      checks++; if (bus.m_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.m_data); end
      checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", bus.m_last); end
      checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", bus.fifo_rd_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %0b expected 0", underrun); end
      checks++; if (seq_num !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", seq_num); end
      #2 rst_n = 1'b1;
   endtask

   task automatic test_full_rate();
      logic [15:0] exp_d[10] = '{16'hA500, 16'd1, 16'd2, 16'd3, 16'd4, 16'hA501, 16'd5, 16'd6, 16'd7, 16'd8};
      logic        exp_l[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 400 && last_count < 2; i++) @(posedge clk);
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++; if (last_count != 2) begin errors++; $display("FAIL full_frames: got %0d frames expected 2", last_count); end
      checks++; if (cap_d.size() != 10) begin errors++; $display("FAIL full_count: got %0d words expected 10", cap_d.size()); end
      for (int i = 0; i < 10 && i < cap_d.size(); i++) begin
         checks++;
         if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL full_word[%0d]: got %h/%0b expected %h/%0b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
         end
      end
      if (cap_c.size() >= 5) begin
         checks++; if (cap_c[4] - cap_c[1] != 3) begin errors++; $display("FAIL full_throughput: got %0d cycles for 4 words expected 3", cap_c[4] - cap_c[1]); end
         checks++; if (cap_c[1] - cap_c[0] != 3) begin errors++; $display("FAIL full_startup: got %0d cycles header-to-word expected 3", cap_c[1] - cap_c[0]); end
      end
      checks++; if (ur_count != 0) begin errors++; $display("FAIL full_underrun: got %0d pulses expected 0", ur_count); end
      checks++; if (reads != 8) begin errors++; $display("FAIL full_reads: got %0d expected 8", reads); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle: got busy=%0b expected 0", busy); end
      checks++; if (seq_num !== 8'd2) begin errors++; $display("FAIL full_seq: got %0d expected 2", seq_num); end
   endtask

   task automatic test_stall();
      logic [15:0] exp_d[10] = '{16'hA500, 16'd1, 16'd2, 16'd3, 16'd4, 16'hA501, 16'd5, 16'd6, 16'd7, 16'd8};
      logic        exp_l[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 800 && last_count < 2; i++) begin
         @(posedge clk);
         #2 bus.m_ready = ~bus.m_ready;
      end
      bus.m_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++; if (cap_d.size() != 10) begin errors++; $display("FAIL stall_count: got %0d words expected 10", cap_d.size()); end
      for (int i = 0; i < 10 && i < cap_d.size(); i++) begin
         checks++;
         if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL stall_word[%0d]: got %h/%0b expected %h/%0b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable stalled cycles expected 0", stall_err); end
      checks++; if (reads != 8) begin errors++; $display("FAIL stall_reads: got %0d expected 8", reads); end
   endtask

   task automatic test_underrun();
      logic [15:0] exp_d[5] = '{16'hA500, 16'd1, 16'd2, 16'd0, 16'd0};
      logic        exp_l[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      fq.push_back(16'd1);
      fq.push_back(16'd2);
      bus.m_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 200 && last_count < 1; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++; if (cap_d.size() != 5) begin errors++; $display("FAIL pad_count: got %0d words expected 5", cap_d.size()); end
      for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
         checks++;
         if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
            errors++;
            $display("FAIL pad_word[%0d]: got %h/%0b expected %h/%0b", i, cap_d[i], cap_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++; if (ur_count != 1) begin errors++; $display("FAIL pad_pulses: got %0d expected 1", ur_count); end
      checks++; if (ur_cyc - last_rd_edge != 8) begin errors++; $display("FAIL pad_delay: got %0d cycles expected 8", ur_cyc - last_rd_edge); end
      checks++; if (reads != 2) begin errors++; $display("FAIL pad_reads: got %0d expected 2", reads); end
      checks++; if (seq_num !== 8'd1) begin errors++; $display("FAIL pad_seq: got %0d expected 1", seq_num); end
   endtask

   task automatic test_enable_drop();
      logic [15:0] exp_d[5] = '{16'hA500, 16'd1, 16'd2, 16'd3, 16'd4};
      do_reset();
      for (int i = 1; i <= 6; i++) fq.push_back(16'(i));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 200 && cap_d.size() < 3; i++) @(posedge clk);
      #2 enable = 1'b0;
      for (int i = 0; i < 200 && last_count < 1; i++) @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++; if (cap_d.size() != 5) begin errors++; $display("FAIL drop_count: got %0d words expected 5", cap_d.size()); end
      for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
         checks++;
         if (cap_d[i] !== exp_d[i]) begin errors++; $display("FAIL drop_word[%0d]: got %h expected %h", i, cap_d[i], exp_d[i]); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %0b expected 0", busy); end
      checks++; if (fq.size() != 2) begin errors++; $display("FAIL drop_left: got %0d unread expected 2", fq.size()); end
      checks++; if (reads != 4) begin errors++; $display("FAIL drop_reads: got %0d expected 4", reads); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 12; i++) fq.push_back(16'(i));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 200 && cap_d.size() < 7; i++) @(posedge clk);
      checks++; if (seq_num !== 8'd1) begin errors++; $display("FAIL mid_seq_before: got %0d expected 1", seq_num); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== 16'h0 || bus.m_last !== 1'b0 || bus.fifo_rd_en !== 1'b0 ||
          underrun !== 1'b0 || busy !== 1'b0 || seq_num !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset: got v=%0b d=%h l=%0b rd=%0b ur=%0b busy=%0b seq=%0d expected all 0",
                  bus.m_valid, bus.m_data, bus.m_last, bus.fifo_rd_en, underrun, busy, seq_num);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      cap_d.delete();
      cap_l.delete();
      cap_c.delete();
      last_count = 0;
      for (int i = 0; i < 200 && cap_d.size() < 1; i++) @(posedge clk);
      checks++;
      if (cap_d.size() < 1) begin errors++; $display("FAIL mid_header: got no word expected a500"); end
      else if (cap_d[0] !== 16'hA500) begin errors++; $display("FAIL mid_header: got %h expected a500", cap_d[0]); end
      #2 enable = 1'b0;
      for (int i = 0; i < 200 && last_count < 1; i++) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      do_reset();
      for (int i = 1; i <= 1028; i++) fq.push_back(16'(i));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 5000 && last_count < 257; i++) @(posedge clk);
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++; if (cap_d.size() != 1285) begin errors++; $display("FAIL wrap_count: got %0d words expected 1285", cap_d.size()); end
      if (cap_d.size() == 1285) begin
         checks++; if (cap_d[255*5] !== 16'hA5FF) begin errors++; $display("FAIL wrap_hdr255: got %h expected a5ff", cap_d[255*5]); end
         checks++; if (cap_d[256*5] !== 16'hA500) begin errors++; $display("FAIL wrap_hdr256: got %h expected a500", cap_d[256*5]); end
         for (int f = 0; f < 257; f++)
            for (int j = 0; j < 4; j++)
               if (cap_d[f*5 + 1 + j] !== 16'(f*4 + j + 1)) bad++;
         checks++; if (bad != 0) begin errors++; $display("FAIL wrap_payload: got %0d wrong words expected 0", bad); end
      end
      checks++; if (seq_num !== 8'd1) begin errors++; $display("FAIL wrap_seq: got %0d expected 1", seq_num); end
      checks++; if (reads != 1028) begin errors++; $display("FAIL wrap_reads: got %0d expected 1028", reads); end
   endtask

   initial begin
      bus.fifo_empty = 1'b1;
      bus.fifo_rdata = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_full_rate();
      test_stall();
      test_underrun();
      test_enable_drop();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
